// File: rtl/queue_1w2r_pkg.sv
// Shared helpers for the 1-write / 2-read circular queue.
// Pointer and count widths stay local to the modules; only the pop-clamping rule lives here.
package queue_1w2r_pkg;

    // Requested pops saturate at 2, then clamp to what is actually held.
    function automatic logic [1:0] clamp_pops(
        input logic [1:0] deq_cnt,
        input logic       has_one,
        input logic       has_two
    );
        logic [1:0] req;
        logic [1:0] pops;
        req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        if (!has_one) begin
            pops = 2'd0;
        end else if (!has_two && (req == 2'd2)) begin
            pops = 2'd1;
        end else begin
            pops = req;
        end
        return pops;
    endfunction

endpackage

// File: rtl/queue_1w2r_ram.sv
// DEPTH x WIDTH register array: two asynchronous read ports, one write port,
// cleared to zero on synchronous reset.
module ram_2r1w #(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [INDEX-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [INDEX-1:0] raddr0,
    input  logic [INDEX-1:0] raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/queue_1w2r.sv
// Circular queue, one enqueue port and two show-ahead dequeue ports.
// Owns head/tail/count and the handshake; storage lives in ram_2r1w.
module queue_1w2r
    import queue_1w2r_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    input  logic [WIDTH-1:0] enq_data_i,
    output logic             enq_ready_o,
    output logic             deq0_valid_o,
    output logic [WIDTH-1:0] deq0_data_o,
    output logic             deq1_valid_o,
    output logic [WIDTH-1:0] deq1_data_o,
    input  logic [1:0]       deq_cnt_i,
    output logic [INDEX:0]   count_o
);

    generate
        if (DEPTH != 2 ** INDEX) begin : g_bad_depth
            $error("queue_1w2r: DEPTH must equal 2**INDEX");
        end
        if (INDEX < 2) begin : g_bad_index
            $error("queue_1w2r: INDEX must be at least 2");
        end
    endgenerate

    localparam logic [INDEX:0] FULL_CNT = (INDEX + 1)'(DEPTH);
    localparam logic [INDEX:0] ONE_CNT  = (INDEX + 1)'(1);

    logic [INDEX-1:0] head;
    logic [INDEX-1:0] tail;
    logic [INDEX-1:0] head_plus1;
    logic [INDEX:0]   count;
    logic [1:0]       pops;
    logic             enq_fire;
    logic             ram_we;

    // Handshake is a pure function of registered count: no pass-through at full.
    assign enq_ready_o  = (count < FULL_CNT);
    assign deq0_valid_o = (count != '0);
    assign deq1_valid_o = (count > ONE_CNT);
    assign count_o      = count;

    assign pops       = clamp_pops(deq_cnt_i, deq0_valid_o, deq1_valid_o);
    assign enq_fire   = enq_valid_i & enq_ready_o;
    assign ram_we     = enq_fire & ~flush_i;
    assign head_plus1 = head + INDEX'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + INDEX'(pops);
            tail  <= tail + INDEX'(enq_fire);
            count <= count + (INDEX + 1)'(enq_fire) - (INDEX + 1)'(pops);
        end
    end

    ram_2r1w #(
        .DEPTH (DEPTH),
        .INDEX (INDEX),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (ram_we),
        .waddr  (tail),
        .wdata  (enq_data_i),
        .raddr0 (head),
        .raddr1 (head_plus1),
        .rdata0 (deq0_data_o),
        .rdata1 (deq1_data_o)
    );

endmodule
